piso_serializer: RTL

Parallel-in, serial-out serializer: the transmit-side counterpart to the team's serial-in shift register. It accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out MSB-first, one bit per clock, with a qualifying valid strobe. A left-shifting SISO receiver clocked on the same edge holds the complete word after WIDTH valid cycles. Back-to-back words stream with no idle gap.

---
 rtl/piso_serializer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out serializer: valid/ready word load, MSB-first serial output.
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
module piso_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load_valid,
    input  logic [WIDTH-1:0] i_pdata,
    output logic             o_load_ready,
    output logic             o_sout,
    output logic             o_sout_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic [1:0]       o_state
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    // Load handshake: a word transfers on a rising edge where i_load_valid and
    // o_load_ready are both 1; o_load_ready depends only on registered state.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1
`ifdef PISO_PARITY_EN
        ,
        S_PARITY = 2'd2
`endif
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_count;
    logic             w_last_bit;
    logic             w_final;
    logic             w_handshake;
`ifdef PISO_PARITY_EN
    logic             r_parity;
`endif

    assign w_last_bit = (r_state == S_SHIFT) && (r_count == '0);
`ifdef PISO_PARITY_EN
    assign w_final    = (r_state == S_PARITY);
`else
    assign w_final    = w_last_bit;
`endif
    assign o_load_ready = (r_state == S_IDLE) || w_final;
    assign w_handshake  = i_load_valid && o_load_ready;
    assign o_state      = r_state;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_handshake) w_state_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (w_last_bit) begin
`ifdef PISO_PARITY_EN
                    w_state_next = S_PARITY;
`else
                    w_state_next = w_handshake ? S_SHIFT : S_IDLE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            S_PARITY: begin
                w_state_next = w_handshake ? S_SHIFT : S_IDLE;
            end
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_sout       = 1'b0;
        o_sout_valid = (r_state != S_IDLE);
        o_busy       = (r_state != S_IDLE);
        o_done       = w_final;
        case (r_state)
            S_SHIFT:  o_sout = r_shreg[WIDTH-1];
`ifdef PISO_PARITY_EN
            S_PARITY: o_sout = r_parity;
`endif
            default:  o_sout = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The counter parks at zero after the last bit; only a handshake reloads it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shreg <= '0;
            r_count <= '0;
        end else if (w_handshake) begin
            r_shreg <= i_pdata;
            r_count <= LAST_CNT;
        end else if (r_state == S_SHIFT) begin
            r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
            if (r_count != '0) r_count <= r_count - 1'b1;
        end
    end

`ifdef PISO_PARITY_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_parity <= 1'b0;
        end else if (w_handshake) begin
            r_parity <= ^i_pdata;
        end
    end
`endif

endmodule
